// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and default sizes for the SRAM bank arbiter
package sram_arb_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 256;
    localparam int MAX_BURST_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOCKED
    } arb_state_e;

    typedef struct packed {
        logic                  en;
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } sram_cmd_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin one-hot select starting at ptr_i
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW-1:0] j;
    int            s;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        s     = 0;
        for (int i = 0; i < N; i++) begin
            s = int'(ptr_i) + i;
            if (s >= N) s = s - N;
            j = IW'(s);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/sram_bank_arbiter.sv
// rtl/sram_bank_arbiter.sv - round-robin SRAM bank arbiter with burst lock; SRAM_ARB_STATS_EN adds counters
module sram_bank_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                      CLK_i,
    input  logic                      RST_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ-1:0]        lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      sram_en_o,
    output logic                      sram_we_o,
    output logic [ADDR_W-1:0]         sram_addr_o,
    output logic [DATA_W-1:0]         sram_wdata_o,
    input  logic [DATA_W-1:0]         sram_rdata_i
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]               gnt_cnt_o [NUM_REQ],
    output logic [31:0]               conflict_cnt_o
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic [NUM_REQ-1:0]  rr_gnt;
    logic [IW-1:0]       rr_idx;
    logic [IW-1:0]       acc_idx;
    logic                accept;

    logic                cmd_en_q, cmd_we_q;
    logic [ADDR_W-1:0]   cmd_addr_q;
    logic [DATA_W-1:0]   cmd_wdata_q;
    logic [NUM_REQ-1:0]  rd1_q, rvalid_q;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] k);
        if (int'(k) == NUM_REQ - 1) return '0;
        return k + IW'(1);
    endfunction

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx)
    );

    always_comb begin
        gnt_o   = '0;
        acc_idx = rr_idx;
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;

        if (state_q == LOCKED) begin
            acc_idx        = owner_q;
            gnt_o[owner_q] = req_i[owner_q];
        end else begin
            gnt_o = rr_gnt;
        end
        if (RST_i) gnt_o = '0;
        accept = |(gnt_o & req_i);

        // Owner dropping its request ends the burst with an idle cycle; others wait one cycle.
        if (state_q == LOCKED) begin
            if (!req_i[owner_q]) begin
                state_d = IDLE;
                burst_d = '0;
            end else begin
                ptr_d = nxt(owner_q);
                if (!lock_i[owner_q] || (int'(burst_q) + 1 >= MAX_BURST)) begin
                    state_d = GRANT;
                    burst_d = '0;
                end else begin
                    burst_d = burst_q + BW'(1);
                end
            end
        end else if (accept) begin
            ptr_d = nxt(acc_idx);
            if (lock_i[acc_idx] && (MAX_BURST > 1)) begin
                state_d = LOCKED;
                owner_d = acc_idx;
                burst_d = BW'(1);
            end else begin
                state_d = GRANT;
                burst_d = '0;
            end
        end else begin
            state_d = IDLE;
            burst_d = '0;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            burst_q     <= '0;
            cmd_en_q    <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rd1_q       <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            burst_q  <= burst_d;
            cmd_en_q <= accept;
            cmd_we_q <= accept & we_i[acc_idx];
            if (accept) begin
                cmd_addr_q  <= addr_i[acc_idx*ADDR_W +: ADDR_W];
                cmd_wdata_q <= wdata_i[acc_idx*DATA_W +: DATA_W];
            end
            rd1_q    <= (accept && !we_i[acc_idx]) ? gnt_o : '0;
            rvalid_q <= rd1_q;
        end
    end

    assign sram_en_o    = cmd_en_q;
    assign sram_we_o    = cmd_we_q;
    assign sram_addr_o  = cmd_addr_q;
    assign sram_wdata_o = cmd_wdata_q;
    assign rvalid_o     = rvalid_q;
    assign rdata_o      = sram_rdata_i;

`ifdef SRAM_ARB_STATS_EN
    logic [31:0]        gnt_cnt_q [NUM_REQ];
    logic [31:0]        conflict_cnt_q;
    logic [NUM_REQ-1:0] others;
    logic               conflict;

    always_comb begin
        others          = req_i;
        others[owner_q] = 1'b0;
        conflict        = ($countones(req_i) >= 2) || ((state_q == LOCKED) && (|others));
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            for (int k = 0; k < NUM_REQ; k++) gnt_cnt_q[k] <= '0;
            conflict_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt_o[k] && req_i[k] && (gnt_cnt_q[k] != '1)) gnt_cnt_q[k] <= gnt_cnt_q[k] + 32'd1;
            end
            if (conflict && (conflict_cnt_q != '1)) conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign gnt_cnt_o      = gnt_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// tb/tb_sram_bank_arbiter.sv - scoreboard bench for sram_bank_arbiter (default build)
module tb_sram_bank_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req, we, lock;
    logic [31:0]   addr;
    logic [1023:0] wdata;
    logic [3:0]    gnt_o, rvalid_o;
    logic [255:0]  rdata_o;
    logic          sram_en_o, sram_we_o;
    logic [7:0]    sram_addr_o;
    logic [255:0]  sram_wdata_o;
    logic [255:0]  sram_rdata;
    logic [255:0]  mem [256];

    typedef struct packed {
        logic [3:0]   who;
        logic [255:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sram_bank_arbiter dut (
        .CLK_i        (clk),
        .RST_i        (rst),
        .req_i        (req),
        .we_i         (we),
        .lock_i       (lock),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .sram_en_o    (sram_en_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata)
    );

    function automatic logic [255:0] pat(input logic [7:0] a);
        return {8{24'hC0DE00, a}};
    endfunction

    initial for (int a = 0; a < 256; a++) mem[a] = pat(8'(a));

    always @(posedge clk) begin
        if (sram_en_o) begin
            if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
            else           sram_rdata <= mem[sram_addr_o];
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && rvalid_o !== 4'b0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected rvalid=%b rdata=%h", rvalid_o, rdata_o);
            end else begin
                e = sb.pop_front();
                if (rvalid_o !== e.who || rdata_o !== e.data) begin
                    bad++;
                    $display("FAIL resp got rvalid=%b rdata=%h want rvalid=%b rdata=%h", rvalid_o, rdata_o, e.who, e.data);
                end
            end
        end
    end

    task automatic idle_inputs();
        req  = '0;
        we   = '0;
        lock = '0;
    endtask

    task automatic drive(input int k, input logic w, input logic l, input logic [7:0] a, input logic [255:0] d);
        req[k]             = 1'b1;
        we[k]              = w;
        lock[k]            = l;
        addr[k*8 +: 8]     = a;
        wdata[k*256 +: 256] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        lock = 4'b1111;
        step();
        step();
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt_o); end
        total++;
        if ({sram_en_o, sram_we_o, sram_addr_o} !== 10'b0) begin
            bad++; $display("FAIL reset_cmd got en=%b we=%b addr=%h want 0", sram_en_o, sram_we_o, sram_addr_o);
        end
        total++;
        if (sram_wdata_o !== 256'b0) begin bad++; $display("FAIL reset_wdata got=%h want=0", sram_wdata_o); end
        total++;
        if (rvalid_o !== 4'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0000", rvalid_o); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        drive(0, 1'b0, 1'b0, 8'h05, '0);
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", gnt_o); end
        sb.push_back({4'b0001, pat(8'h05)});
        step();
        idle_inputs();
        @(negedge clk);
        total++;
        if ({sram_en_o, sram_we_o, sram_addr_o} !== {1'b1, 1'b0, 8'h05}) begin
            bad++; $display("FAIL single_cmd got en=%b we=%b addr=%h want en=1 we=0 addr=05", sram_en_o, sram_we_o, sram_addr_o);
        end
        total++;
        if (rvalid_o !== 4'b0) begin bad++; $display("FAIL single_early_rvalid got=%b want=0000", rvalid_o); end
        step();
        @(negedge clk);
        total++;
        if (rvalid_o !== 4'b0001) begin bad++; $display("FAIL single_rvalid got=%b want=0001", rvalid_o); end
        drain();
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        do_reset();
        for (int k = 0; k < 4; k++) drive(k, 1'b0, 1'b0, 8'h20 + 8'(k), '0);
        for (int i = 0; i < 8; i++) begin
            eg = 4'b0001 << (i % 4);
            @(negedge clk);
            total++;
            if (gnt_o !== eg) begin bad++; $display("FAIL rr_gnt cycle=%0d got=%b want=%b", i, gnt_o, eg); end
            sb.push_back({eg, pat(8'h20 + 8'(i % 4))});
            step();
        end
        drain();
    endtask

    task automatic test_burst_lock();
        logic [3:0] eg;
        do_reset();
        drive(1, 1'b0, 1'b1, 8'h41, '0);
        for (int i = 0; i < 18; i++) begin
            if (i == 1) begin
                drive(0, 1'b0, 1'b0, 8'h40, '0);
                drive(2, 1'b0, 1'b0, 8'h42, '0);
            end
            eg = (i < 16) ? 4'b0010 : ((i == 16) ? 4'b0100 : 4'b0001);
            @(negedge clk);
            total++;
            if (gnt_o !== eg) begin bad++; $display("FAIL burst_gnt cycle=%0d got=%b want=%b", i, gnt_o, eg); end
            sb.push_back({eg, pat((i < 16) ? 8'h41 : ((i == 16) ? 8'h42 : 8'h40))});
            step();
        end
        drain();
    endtask

    task automatic test_write_read();
        do_reset();
        drive(2, 1'b1, 1'b0, 8'h10, {32{8'hA5}});
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0100) begin bad++; $display("FAIL wr_gnt got=%b want=0100", gnt_o); end
        step();
        idle_inputs();
        drive(0, 1'b0, 1'b0, 8'h10, '0);
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0001) begin bad++; $display("FAIL rd_after_wr_gnt got=%b want=0001", gnt_o); end
        total++;
        if ({sram_en_o, sram_we_o, sram_addr_o} !== {1'b1, 1'b1, 8'h10} || sram_wdata_o !== {32{8'hA5}}) begin
            bad++; $display("FAIL wr_cmd got en=%b we=%b addr=%h wdata=%h want en=1 we=1 addr=10 wdata=a5..", sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o);
        end
        sb.push_back({4'b0001, {32{8'hA5}}});
        step();
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 1'b0, 1'b0, 8'h07, '0);
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0001) begin bad++; $display("FAIL mid_gnt got=%b want=0001", gnt_o); end
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        @(negedge clk);
        total++;
        if ({sram_en_o, sram_we_o, sram_addr_o} !== 10'b0 || rvalid_o !== 4'b0 || gnt_o !== 4'b0) begin
            bad++; $display("FAIL mid_rst_outputs got en=%b we=%b addr=%h rvalid=%b gnt=%b want all 0", sram_en_o, sram_we_o, sram_addr_o, rvalid_o, gnt_o);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) drive(k, 1'b0, 1'b0, 8'h60 + 8'(k), '0);
        @(negedge clk);
        total++;
        if (rvalid_o !== 4'b0) begin bad++; $display("FAIL mid_dropped_rvalid got=%b want=0000", rvalid_o); end
        total++;
        if (gnt_o !== 4'b0001) begin bad++; $display("FAIL mid_ptr_restart got=%b want=0001", gnt_o); end
        sb.push_back({4'b0001, pat(8'h60)});
        step();
        drain();
    endtask

    task automatic test_lock_drop();
        do_reset();
        drive(1, 1'b0, 1'b1, 8'h51, '0);
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0010) begin bad++; $display("FAIL drop_gnt0 got=%b want=0010", gnt_o); end
        sb.push_back({4'b0010, pat(8'h51)});
        step();
        drive(0, 1'b0, 1'b0, 8'h50, '0);
        drive(2, 1'b0, 1'b0, 8'h52, '0);
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0010) begin bad++; $display("FAIL drop_gnt1 got=%b want=0010", gnt_o); end
        sb.push_back({4'b0010, pat(8'h51)});
        step();
        req[1]  = 1'b0;
        lock[1] = 1'b0;
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0000) begin bad++; $display("FAIL drop_idle_gnt got=%b want=0000", gnt_o); end
        step();
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0100) begin bad++; $display("FAIL drop_after_gnt2 got=%b want=0100", gnt_o); end
        sb.push_back({4'b0100, pat(8'h52)});
        step();
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0001) begin bad++; $display("FAIL drop_after_gnt0 got=%b want=0001", gnt_o); end
        sb.push_back({4'b0001, pat(8'h50)});
        step();
        drain();
    endtask

    task automatic test_single_locked();
        do_reset();
        drive(3, 1'b1, 1'b1, 8'h70, {8{32'h5A5A_0F0F}});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (gnt_o !== 4'b1000) begin bad++; $display("FAIL solo_gnt cycle=%0d got=%b want=1000", i, gnt_o); end
            step();
        end
        @(negedge clk);
        total++;
        if ({sram_en_o, sram_we_o, sram_addr_o} !== {1'b1, 1'b1, 8'h70}) begin
            bad++; $display("FAIL solo_cmd got en=%b we=%b addr=%h want en=1 we=1 addr=70", sram_en_o, sram_we_o, sram_addr_o);
        end
        drain();
    endtask

    task automatic test_lock_without_req();
        do_reset();
        lock = 4'b1111;
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0000) begin bad++; $display("FAIL lonely_lock_gnt got=%b want=0000", gnt_o); end
        step();
        drive(0, 1'b0, 1'b0, 8'h80, '0);
        drive(1, 1'b0, 1'b0, 8'h81, '0);
        @(negedge clk);
        total++;
        if (sram_en_o !== 1'b0) begin bad++; $display("FAIL lonely_lock_en got=%b want=0", sram_en_o); end
        total++;
        if (gnt_o !== 4'b0001) begin bad++; $display("FAIL lonely_gnt0 got=%b want=0001", gnt_o); end
        sb.push_back({4'b0001, pat(8'h80)});
        step();
        @(negedge clk);
        total++;
        if (gnt_o !== 4'b0010) begin bad++; $display("FAIL lonely_gnt1 got=%b want=0010", gnt_o); end
        sb.push_back({4'b0010, pat(8'h81)});
        step();
        drain();
    endtask

    initial begin
        rst   = 1'b1;
        idle_inputs();
        addr  = '0;
        wdata = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst_lock();
        test_write_read();
        test_reset_mid();
        test_lock_drop();
        test_single_locked();
        test_lock_without_req();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
